// File: rtl/fm_radio_pkg.sv
// Shared FM front-end types and defaults: sample width, I/Q sequencer state
// encoding and the sequencer's default credit / skew constants.
package fm_radio_pkg;

  localparam int unsigned SAMPLE_W          = 32;
  localparam int unsigned IQ_SEQ_CREDITS    = 8;
  localparam int unsigned IQ_SEQ_SKEW_LIMIT = 16;
  localparam int unsigned IQ_SEQ_DECIM_W    = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_ERROR = 2'd3
  } iq_seq_state_t;

endpackage

// File: rtl/iq_fir_sequencer_if.sv
// Bundle of the I/Q input FIFO heads, core sample/result handshakes and the
// real/imag output FIFO write ports seen by the I/Q FIR sequencer.
interface iq_fir_sequencer_if;
  import fm_radio_pkg::*;

  logic [SAMPLE_W-1:0] i_dout;
  logic [SAMPLE_W-1:0] q_dout;
  logic                i_empty;
  logic                q_empty;
  logic                i_rd_en;
  logic                q_rd_en;

  logic [SAMPLE_W-1:0] core_i;
  logic [SAMPLE_W-1:0] core_q;
  logic                core_valid;
  logic                core_ready;

  logic [SAMPLE_W-1:0] res_real;
  logic [SAMPLE_W-1:0] res_imag;
  logic                res_valid;
  logic                res_ready;

  logic [SAMPLE_W-1:0] real_din;
  logic [SAMPLE_W-1:0] imag_din;
  logic                real_wr_en;
  logic                imag_wr_en;
  logic                real_full;
  logic                imag_full;

  // Sequencer side
  modport master (
    input  i_dout, q_dout, i_empty, q_empty,
    output i_rd_en, q_rd_en,
    output core_i, core_q, core_valid,
    input  core_ready,
    input  res_real, res_imag, res_valid,
    output res_ready,
    output real_din, imag_din, real_wr_en, imag_wr_en,
    input  real_full, imag_full
  );

  // FIFO / core side
  modport slave (
    output i_dout, q_dout, i_empty, q_empty,
    input  i_rd_en, q_rd_en,
    input  core_i, core_q, core_valid,
    output core_ready,
    output res_real, res_imag, res_valid,
    input  res_ready,
    input  real_din, imag_din, real_wr_en, imag_wr_en,
    output real_full, imag_full
  );

endinterface

// File: rtl/credit_counter.sv
// In-flight credit pool: dec takes a credit, inc returns one, saturating at
// 0 and CREDITS. all_returned looks through this cycle's update.
module credit_counter #(
  parameter int unsigned CREDITS = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic inc,
  input  logic dec,
  output logic avail,
  output logic all_returned
);

  localparam int unsigned CNT_W = $clog2(CREDITS + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(CREDITS);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Simultaneous inc and dec cancel out
  always_comb begin
    count_d = count_q;
    if (inc && !dec && (count_q != FULL)) begin
      count_d = count_q + CNT_W'(1);
    end else if (dec && !inc && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      count_q <= FULL;
    end else begin
      count_q <= count_d;
    end
  end

  assign avail        = (count_q != '0);
  assign all_returned = (count_d == FULL);

endmodule

// File: rtl/iq_fir_sequencer.sv
// Lockstep I/Q -> fir_complex -> real/imag FIFO sequencer with credits,
// runtime decimation, skew detection and drain. Optional statistics
// counters are built when IQ_SEQ_STATS_EN is defined.
module iq_fir_sequencer
  import fm_radio_pkg::*;
#(
  parameter int unsigned CREDITS    = IQ_SEQ_CREDITS,
  parameter int unsigned SKEW_LIMIT = IQ_SEQ_SKEW_LIMIT,
  parameter int unsigned DECIM_W    = IQ_SEQ_DECIM_W
) (
  input  logic                clock,
  input  logic                reset,
  iq_fir_sequencer_if.master  bus,
  input  logic [DECIM_W-1:0]  decim,
  input  logic                start,
  input  logic                flush,
  output logic                busy,
  output logic                desync_err,
  output logic [SAMPLE_W-1:0] issued_cnt,
  output logic [SAMPLE_W-1:0] fwd_cnt
);

  localparam int unsigned SKEW_W = $clog2(SKEW_LIMIT + 1);

  iq_seq_state_t      state_q;
  iq_seq_state_t      state_d;
  logic [DECIM_W-1:0] decim_q;
  logic [DECIM_W-1:0] decim_d;
  logic [DECIM_W-1:0] dec_cnt_q;
  logic [DECIM_W-1:0] dec_cnt_d;
  logic [SKEW_W-1:0]  skew_q;
  logic [SKEW_W-1:0]  skew_d;
  logic               desync_q;
  logic               desync_d;

  logic avail;
  logic all_returned;
  logic issue;
  logic res_en;
  logic keep;
  logic out_room;
  logic consume;
  logic write;

  credit_counter #(
    .CREDITS (CREDITS)
  ) u_credits (
    .clock        (clock),
    .reset        (reset),
    .inc          (consume),
    .dec          (issue),
    .avail        (avail),
    .all_returned (all_returned)
  );

  // Issue and result paths are combinational so a pair moves every cycle
  always_comb begin
    issue    = (state_q == ST_RUN) && !bus.i_empty && !bus.q_empty &&
               bus.core_ready && avail;
    res_en   = (state_q == ST_RUN) || (state_q == ST_DRAIN) || (state_q == ST_ERROR);
    keep     = (dec_cnt_q == '0);
    out_room = !bus.real_full && !bus.imag_full;
    consume  = res_en && bus.res_valid && (!keep || out_room);
    write    = res_en && bus.res_valid && keep && out_room;
  end

  assign bus.i_rd_en    = issue;
  assign bus.q_rd_en    = issue;
  assign bus.core_valid = issue;
  assign bus.core_i     = bus.i_dout;
  assign bus.core_q     = bus.q_dout;
  assign bus.res_ready  = consume;
  assign bus.real_wr_en = write;
  assign bus.imag_wr_en = write;
  assign bus.real_din   = bus.res_real;
  assign bus.imag_din   = bus.res_imag;

  // Next-state, decimation phase, skew tracking and sticky error
  always_comb begin
    state_d   = state_q;
    decim_d   = decim_q;
    dec_cnt_d = dec_cnt_q;
    skew_d    = '0;
    desync_d  = desync_q;

    if (consume) begin
      dec_cnt_d = (dec_cnt_q == (decim_q - DECIM_W'(1))) ? '0 : (dec_cnt_q + DECIM_W'(1));
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          decim_d = (decim == '0) ? DECIM_W'(1) : decim;
        end
      end
      ST_RUN: begin
        if (bus.i_empty != bus.q_empty) begin
          skew_d = skew_q + SKEW_W'(1);
        end
        if (skew_d == SKEW_W'(SKEW_LIMIT)) begin
          desync_d = 1'b1;
          state_d  = ST_ERROR;
        end
        if (flush) begin
          state_d = ST_DRAIN;
        end
      end
      ST_ERROR: begin
        if (flush) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (all_returned) begin
          state_d   = ST_IDLE;
          dec_cnt_d = '0;
          skew_d    = '0;
          desync_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      decim_q   <= DECIM_W'(1);
      dec_cnt_q <= '0;
      skew_q    <= '0;
      desync_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      decim_q   <= decim_d;
      dec_cnt_q <= dec_cnt_d;
      skew_q    <= skew_d;
      desync_q  <= desync_d;
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign desync_err = desync_q;

`ifdef IQ_SEQ_STATS_EN
  logic [SAMPLE_W-1:0] issued_q;
  logic [SAMPLE_W-1:0] fwd_q;

  // Free-running wrap-around statistics, cleared only by reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      issued_q <= '0;
      fwd_q    <= '0;
    end else begin
      if (issue) begin
        issued_q <= issued_q + SAMPLE_W'(1);
      end
      if (write) begin
        fwd_q <= fwd_q + SAMPLE_W'(1);
      end
    end
  end

  assign issued_cnt = issued_q;
  assign fwd_cnt    = fwd_q;
`else
  assign issued_cnt = '0;
  assign fwd_cnt    = '0;
`endif

endmodule

// File: tb/tb_iq_fir_sequencer.sv
// Scoreboard bench for iq_fir_sequencer: queue-backed I/Q FIFOs, a latency-3
// complex core model and an output-write scoreboard.
module tb_iq_fir_sequencer;
  import fm_radio_pkg::*;

  localparam int unsigned LAT = 3;

  typedef struct packed {
    logic [31:0] re;
    logic [31:0] im;
    int unsigned rdy;
  } core_ent_t;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  decim;
  logic        start;
  logic        flush;
  logic        busy;
  logic        desync_err;
  logic [31:0] issued_cnt;
  logic [31:0] fwd_cnt;

  iq_fir_sequencer_if bus ();

  iq_fir_sequencer #(
    .CREDITS    (8),
    .SKEW_LIMIT (16),
    .DECIM_W    (4)
  ) u_dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus),
    .decim      (decim),
    .start      (start),
    .flush      (flush),
    .busy       (busy),
    .desync_err (desync_err),
    .issued_cnt (issued_cnt),
    .fwd_cnt    (fwd_cnt)
  );

  always #5 clock = ~clock;

  logic [31:0] i_fifo[$];
  logic [31:0] q_fifo[$];
  core_ent_t   pipe[$];
  logic [63:0] exp_q[$];

  int unsigned cyc, n_pops, n_writes, n_drop_full, res_idx, sb_idx;
  int unsigned st_base_p, st_base_w, drop_base;
  bit          core_hold, force_real_full, force_imag_full, drop_mode;
  int unsigned n_checks, n_errors;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive FIFO heads, core result and full flags from the model state
  task automatic drive();
    bus.i_empty    = (i_fifo.size() == 0);
    bus.q_empty    = (q_fifo.size() == 0);
    bus.i_dout     = (i_fifo.size() != 0) ? i_fifo[0] : 32'h0;
    bus.q_dout     = (q_fifo.size() != 0) ? q_fifo[0] : 32'h0;
    bus.core_ready = 1'b1;
    bus.res_valid  = !core_hold && (pipe.size() != 0) && (cyc >= pipe[0].rdy);
    bus.res_real   = (pipe.size() != 0) ? pipe[0].re : 32'h0;
    bus.res_imag   = (pipe.size() != 0) ? pipe[0].im : 32'h0;
    bus.real_full  = force_real_full || (drop_mode && (((res_idx - drop_base) % 4) != 0));
    bus.imag_full  = force_imag_full;
  endtask

  // Samples handshakes at negedge, applies them after the following posedge
  task automatic model_loop();
    logic ev_pop, ev_cons, ev_wr;
    logic [63:0] e;
    forever begin
      @(negedge clock);
      ev_pop  = bus.i_rd_en;
      ev_cons = bus.res_ready && bus.res_valid;
      ev_wr   = bus.real_wr_en;
      if (bus.i_rd_en || bus.q_rd_en || bus.core_valid) begin
        check("pop_i", 64'(bus.i_rd_en), 64'(1));
        check("pop_q", 64'(bus.q_rd_en), 64'(1));
        check("core_valid", 64'(bus.core_valid), 64'(1));
        if (i_fifo.size() != 0 && q_fifo.size() != 0)
          check("core_iq", {bus.core_i, bus.core_q}, {i_fifo[0], q_fifo[0]});
        else
          check("pop_empty", 64'(1), 64'(0));
      end
      if (bus.real_wr_en || bus.imag_wr_en) begin
        check("wr_real", 64'(bus.real_wr_en), 64'(1));
        check("wr_imag", 64'(bus.imag_wr_en), 64'(1));
        check("wr_res_ready", 64'(bus.res_ready), 64'(1));
        if (exp_q.size() == 0) begin
          check("wr_unexpected", 64'(1), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check("wr_data", {bus.real_din, bus.imag_din}, e);
        end
      end
      if (ev_cons && bus.real_full) n_drop_full++;
      @(posedge clock);
      #1;
      if (!reset) begin
        pipe.delete();
      end else begin
        if (ev_cons && pipe.size() != 0) begin
          void'(pipe.pop_front());
          res_idx++;
        end
        if (ev_pop && i_fifo.size() != 0 && q_fifo.size() != 0) begin
          pipe.push_back('{re: i_fifo[0] + q_fifo[0], im: i_fifo[0] - q_fifo[0], rdy: cyc + LAT});
          void'(i_fifo.pop_front());
          void'(q_fifo.pop_front());
          n_pops++;
        end
        if (ev_wr) n_writes++;
      end
      cyc++;
      #2;
      drive();
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic push_pair(input logic [31:0] i, input logic [31:0] q, input int unsigned eff);
    i_fifo.push_back(i);
    q_fifo.push_back(q);
    if ((sb_idx % eff) == 0) exp_q.push_back({i + q, i - q});
    sb_idx++;
  endtask

  task automatic start_run(input logic [3:0] d);
    decim = d;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_writes(input string tag, input int unsigned target, input int unsigned budget);
    for (int k = 0; k < int'(budget) && n_writes < target; k++) tick();
    check(tag, 64'(n_writes), 64'(target));
  endtask

  task automatic drain(input string tag);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int k = 0; k < 200 && busy; k++) tick();
    check({tag, "_idle"}, 64'(busy), 64'(0));
    check({tag, "_credits"}, 64'(u_dut.u_credits.count_q), 64'(8));
  endtask

  task automatic check_stats(input string tag);
`ifdef IQ_SEQ_STATS_EN
    check({tag, "_issued_cnt"}, 64'(issued_cnt), 64'(n_pops - st_base_p));
    check({tag, "_fwd_cnt"}, 64'(fwd_cnt), 64'(n_writes - st_base_w));
`else
    check({tag, "_issued_cnt"}, 64'(issued_cnt), 64'(0));
    check({tag, "_fwd_cnt"}, 64'(fwd_cnt), 64'(0));
`endif
  endtask

  initial begin
    int unsigned bp, bw, bd, br;
    reset = 1'b0; start = 1'b0; flush = 1'b0; decim = 4'd1;
    drive();
    fork
      model_loop();
    join_none

    // Reset state
    repeat (3) tick();
    @(negedge clock);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_desync", 64'(desync_err), 64'(0));
    check("rst_core_valid", 64'(bus.core_valid), 64'(0));
    check("rst_res_ready", 64'(bus.res_ready), 64'(0));
    check("rst_wr", 64'(bus.real_wr_en), 64'(0));
    check("rst_credits", 64'(u_dut.u_credits.count_q), 64'(8));
    check_stats("rst");
    reset = 1'b1;
    tick();

    // decim=1, 20 preloaded pairs
    sb_idx = 0; bp = n_pops; bw = n_writes;
    for (int k = 0; k < 20; k++) push_pair(32'h100 + 32'(k), 32'h2000 + 32'(3 * k), 1);
    tick();
    check("t1_idle_no_pop", 64'(n_pops - bp), 64'(0));
    start_run(4'd1);
    wait_writes("t1_writes", bw + 20, 200);
    check("t1_pops", 64'(n_pops - bp), 64'(20));
    drain("t1");
    check_stats("t1");

    // decim=4, dropped results consumed under real_full
    sb_idx = 0; bw = n_writes; bd = n_drop_full; drop_base = res_idx; drop_mode = 1'b1;
    for (int k = 0; k < 16; k++) push_pair(32'hA000 + 32'(k * 7), 32'h0F00 - 32'(k), 4);
    start_run(4'd4);
    for (int k = 0; k < 200 && (res_idx - drop_base) < 16; k++) tick();
    check("t2_results", 64'(res_idx - drop_base), 64'(16));
    check("t2_writes", 64'(n_writes - bw), 64'(4));
    check("t2_drop_full", 64'(n_drop_full - bd), 64'(12));
    check_stats("t2");
    drop_mode = 1'b0;
    drain("t2");

    // Core withholds results: credits cap in-flight issues at 8
    sb_idx = 0; bp = n_pops; bw = n_writes; core_hold = 1'b1;
    for (int k = 0; k < 20; k++) push_pair(32'h3_0000 + 32'(k), 32'h5 * 32'(k + 1), 1);
    start_run(4'd1);
    repeat (100) tick();
    check("t3_issued", 64'(n_pops - bp), 64'(8));
    @(negedge clock);
    check("t3_core_valid", 64'(bus.core_valid), 64'(0));
    check("t3_no_writes", 64'(n_writes - bw), 64'(0));
    core_hold = 1'b0;
    wait_writes("t3_writes", bw + 20, 300);
    check("t3_pops", 64'(n_pops - bp), 64'(20));
    drain("t3");

    // imag_full alone blocks the paired write; decim=0 acts as 1
    sb_idx = 0; bw = n_writes; force_imag_full = 1'b1;
    push_pair(32'hCAFE_0001, 32'h0000_1234, 1);
    start_run(4'd0);
    repeat (10) tick();
    @(negedge clock);
    check("t4_res_valid", 64'(bus.res_valid), 64'(1));
    check("t4_res_ready", 64'(bus.res_ready), 64'(0));
    check("t4_real_wr", 64'(bus.real_wr_en), 64'(0));
    check("t4_imag_wr", 64'(bus.imag_wr_en), 64'(0));
    force_imag_full = 1'b0;
    wait_writes("t4_write", bw + 1, 20);
    repeat (5) tick();
    check("t4_single", 64'(n_writes - bw), 64'(1));
    drain("t4");

    // I/Q skew: error on the 16th mismatched cycle, then no pops
    bp = n_pops;
    start_run(4'd1);
    i_fifo.push_back(32'hDEAD_0000);
    repeat (15) tick();
    check("t5_before_limit", 64'(desync_err), 64'(0));
    tick();
    check("t5_desync", 64'(desync_err), 64'(1));
    check("t5_state", 64'(u_dut.state_q), 64'(ST_ERROR));
    q_fifo.push_back(32'hBEEF_0000);
    repeat (5) tick();
    check("t5_no_pop", 64'(n_pops - bp), 64'(0));
    check("t5_still_err", 64'(desync_err), 64'(1));
    drain("t5");
    check("t5_desync_clr", 64'(desync_err), 64'(0));
    i_fifo.delete();
    q_fifo.delete();
    tick();

    // Reset with 5 samples in flight
    sb_idx = 0; bp = n_pops; core_hold = 1'b1;
    for (int k = 0; k < 5; k++) push_pair(32'h77 + 32'(k), 32'h99, 1);
    start_run(4'd1);
    repeat (10) tick();
    check("t6_in_flight", 64'(n_pops - bp), 64'(5));
    br = res_idx;
    reset = 1'b0;
    tick();
    @(negedge clock);
    check("t6_busy", 64'(busy), 64'(0));
    check("t6_credits", 64'(u_dut.u_credits.count_q), 64'(8));
    check("t6_core_valid", 64'(bus.core_valid), 64'(0));
    check("t6_res_ready", 64'(bus.res_ready), 64'(0));
    check("t6_wr", 64'(bus.real_wr_en), 64'(0));
    check("t6_desync", 64'(desync_err), 64'(0));
    check("t6_issued_cnt", 64'(issued_cnt), 64'(0));
    check("t6_fwd_cnt", 64'(fwd_cnt), 64'(0));
    check("t6_no_consume", 64'(res_idx - br), 64'(0));
    exp_q.delete();
    core_hold = 1'b0;
    tick();
    reset = 1'b1;
    st_base_p = n_pops;
    st_base_w = n_writes;
    tick();

    // Short run after reset to confirm recovery
    sb_idx = 0; bw = n_writes;
    for (int k = 0; k < 6; k++) push_pair(32'h4000 + 32'(k), 32'h10 + 32'(k), 2);
    start_run(4'd2);
    wait_writes("t7_writes", bw + 3, 100);
    drain("t7");
    check_stats("t7");
    check("sb_empty", 64'(exp_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
